// File: rtl/stereo_stream_aligner.sv
// Aligns an early stream A against a late stream B through a small FIFO and emits matched pairs.
// Optional watermark output max_level is enabled by defining ALIGN_WATERMARK_EN.
module stereo_stream_aligner #(
    parameter int N     = 8,
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          a_valid,
    input  logic [N-1:0]  a_data,
    input  logic          b_valid,
    input  logic [N-1:0]  b_data,
    output logic          o_valid,
    output logic [N-1:0]  o_a_data,
    output logic [N-1:0]  o_b_data,
    output logic [LW-1:0] level,
    output logic          overflow,
    output logic          underflow
`ifdef ALIGN_WATERMARK_EN
    ,
    output logic [LW-1:0] max_level
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
    localparam logic [LW-1:0] LVL_ONE = LW'(1);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ERR = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [N-1:0]  r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   w_wr_ptr_next;
    logic [AW:0]   w_rd_ptr_next;
    logic [LW-1:0] r_level;
    logic [LW-1:0] w_level_next;

    logic          r_o_valid;
    logic [N-1:0]  r_o_a_data;
    logic [N-1:0]  r_o_b_data;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_bypass;
    logic          w_underflow_evt;
    logic          w_overflow_evt;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Event decode; B is resolved first so a same-cycle pop can make room for A.
    always_comb begin
        w_pop           = 1'b0;
        w_bypass        = 1'b0;
        w_push          = 1'b0;
        w_underflow_evt = 1'b0;
        w_overflow_evt  = 1'b0;
        w_state_next    = r_state;
        if (clr) begin
            w_state_next = ST_RUN;
        end else if (r_state == ST_RUN) begin
            if (b_valid) begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                end else if (a_valid) begin
                    w_bypass = 1'b1;
                end else begin
                    w_underflow_evt = 1'b1;
                end
            end
            if (a_valid && !w_bypass) begin
                if (!w_full || w_pop) begin
                    w_push = 1'b1;
                end else begin
                    w_overflow_evt = 1'b1;
                end
            end
            if (w_underflow_evt || w_overflow_evt) begin
                w_state_next = ST_ERR;
            end
        end
    end

    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_level_next  = r_level;
        if (clr) begin
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
            w_level_next  = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_next = r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                w_rd_ptr_next = r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                w_level_next = r_level + LVL_ONE;
            end else if (w_pop && !w_push) begin
                w_level_next = r_level - LVL_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_level  <= w_level_next;
        end
    end

    // Storage array carries no reset so it maps onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= a_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o_valid   <= 1'b0;
            r_o_a_data  <= '0;
            r_o_b_data  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_o_valid   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_o_valid <= w_pop || w_bypass;
            if (w_pop) begin
                r_o_a_data <= r_mem[r_rd_ptr[AW-1:0]];
                r_o_b_data <= b_data;
            end else if (w_bypass) begin
                r_o_a_data <= a_data;
                r_o_b_data <= b_data;
            end
            if (w_overflow_evt) begin
                r_overflow <= 1'b1;
            end
            if (w_underflow_evt) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef ALIGN_WATERMARK_EN
    logic [LW-1:0] r_max_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_level <= '0;
        end else if (clr) begin
            r_max_level <= '0;
        end else if (w_level_next > r_max_level) begin
            r_max_level <= w_level_next;
        end
    end

    assign max_level = r_max_level;
`else
    // Without the watermark only the live occupancy is reported.
`endif

    assign o_valid   = r_o_valid;
    assign o_a_data  = r_o_a_data;
    assign o_b_data  = r_o_b_data;
    assign level     = r_level;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_stereo_stream_aligner.sv
// Scoreboard bench for stereo_stream_aligner: a queue-based model predicts pairs, level and flags.
module tb_stereo_stream_aligner;

    localparam int N     = 8;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          a_valid;
    logic [N-1:0]  a_data;
    logic          b_valid;
    logic [N-1:0]  b_data;
    logic          o_valid;
    logic [N-1:0]  o_a_data;
    logic [N-1:0]  o_b_data;
    logic [LW-1:0] level;
    logic          overflow;
    logic          underflow;
`ifdef ALIGN_WATERMARK_EN
    logic [LW-1:0] max_level;
`endif

    always #5 clk = ~clk;

    stereo_stream_aligner #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .o_valid   (o_valid),
        .o_a_data  (o_a_data),
        .o_b_data  (o_b_data),
        .level     (level),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef ALIGN_WATERMARK_EN
        ,
        .max_level (max_level)
`endif
    );

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
    } pair_t;

    // Reference model: A samples waiting for a partner, sticky flags, error lockout.
    logic [N-1:0] mq[$];
    pair_t        exp_q[$];
    bit           m_err, m_of, m_uf;
    int           m_maxl;
    logic [N-1:0] last_a, last_b;
    int           n_checks = 0;
    int           n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_clear();
        mq.delete();
        exp_q.delete();
        m_err = 0; m_of = 0; m_uf = 0; m_maxl = 0;
    endtask

    // Drive one cycle of inputs and predict what the next rising edge produces.
    task automatic step(input bit c, input bit av, input logic [N-1:0] ad,
                        input bit bv, input logic [N-1:0] bd);
        pair_t p;
        @(negedge clk);
        clr = c; a_valid = av; a_data = ad; b_valid = bv; b_data = bd;
        if (c) begin
            model_clear();
        end else if (!m_err) begin
            if (bv && mq.size() > 0) begin
                p.a = mq.pop_front(); p.b = bd;
                exp_q.push_back(p);
                if (av) mq.push_back(ad);
            end else if (bv && av) begin
                p.a = ad; p.b = bd;
                exp_q.push_back(p);
            end else if (bv) begin
                m_uf = 1; m_err = 1;
            end else if (av) begin
                if (mq.size() == DEPTH) begin
                    m_of = 1; m_err = 1;
                end else begin
                    mq.push_back(ad);
                end
            end
            if (mq.size() > m_maxl) m_maxl = mq.size();
        end
    endtask

    // Monitor: one edge after each input cycle, compare against the model.
    always @(posedge clk) begin
        pair_t p;
        bit    exp_v;
        #1;
        if (rst_n) begin
            exp_v = (exp_q.size() != 0);
            chk("o_valid", int'(o_valid), int'(exp_v));
            if (exp_v) begin
                p = exp_q.pop_front();
                last_a = p.a; last_b = p.b;
                $display("pair a=0x%02h b=0x%02h level=%0d", o_a_data, o_b_data, level);
            end
            chk("o_a_data", int'(o_a_data), int'(last_a));
            chk("o_b_data", int'(o_b_data), int'(last_b));
            chk("level", int'(level), mq.size());
            chk("overflow", int'(overflow), int'(m_of));
            chk("underflow", int'(underflow), int'(m_uf));
`ifdef ALIGN_WATERMARK_EN
            chk("max_level", int'(max_level), m_maxl);
`endif
        end
    end

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_o_valid"}, int'(o_valid), 0);
        chk({tag, "_o_a_data"}, int'(o_a_data), 0);
        chk({tag, "_o_b_data"}, int'(o_b_data), 0);
        chk({tag, "_level"}, int'(level), 0);
        chk({tag, "_overflow"}, int'(overflow), 0);
        chk({tag, "_underflow"}, int'(underflow), 0);
    endtask

    initial begin
        rst_n = 1'b0; clr = 0; a_valid = 0; a_data = '0; b_valid = 0; b_data = '0;
        last_a = '0; last_b = '0;
        model_clear();
        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Skew of three cycles: A from cycle 0, B from cycle 3.
        for (int i = 0; i < 3; i++) step(0, 1, N'(8'h10 + i), 0, '0);
        for (int i = 0; i < 20; i++) step(0, 1, N'(8'h13 + i), 1, N'($urandom));
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1, N'($urandom));
        step(0, 0, '0, 0, '0);

        // Zero skew: bypass path.
        step(0, 1, 8'h55, 1, 8'hAA);
        step(0, 0, '0, 0, '0);

        // Underflow, then locked-out traffic, then clear.
        step(0, 0, '0, 1, 8'h01);
        for (int i = 0; i < 6; i++) step(0, $urandom_range(0, 1), N'($urandom), $urandom_range(0, 1), N'($urandom));
        step(1, 1, 8'hEE, 1, 8'hDD);
        step(0, 0, '0, 0, '0);

        // Overflow on the 17th push, then the same with a pop alongside.
        for (int i = 0; i < DEPTH; i++) step(0, 1, N'(8'h80 + i), 0, '0);
        step(0, 1, 8'hFF, 0, '0);
        step(0, 0, '0, 0, '0);
        step(1, 0, '0, 0, '0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, N'(8'h40 + i), 0, '0);
        step(0, 1, 8'h7E, 1, 8'hC3);
        for (int i = 0; i < DEPTH; i++) step(0, 0, '0, 1, N'($urandom));
        step(0, 0, '0, 0, '0);

        // Watermark pattern: fill to 7, drain to 2, then clear.
        step(1, 0, '0, 0, '0);
        for (int i = 0; i < 7; i++) step(0, 1, N'(8'h20 + i), 0, '0);
        for (int i = 0; i < 5; i++) step(0, 0, '0, 1, N'(8'h30 + i));
        step(0, 0, '0, 0, '0);
        step(1, 0, '0, 0, '0);
        step(0, 0, '0, 0, '0);

        // Randomised traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            bit c;
            c = ($urandom_range(0, 59) == 0) || (m_err && $urandom_range(0, 3) == 0);
            step(c, $urandom_range(0, 99) < 62, N'($urandom), $urandom_range(0, 99) < 58, N'($urandom));
        end
        step(1, 0, '0, 0, '0);

        // Asynchronous reset mid-cycle with five samples held.
        for (int i = 0; i < 5; i++) step(0, 1, N'(8'hA0 + i), 0, '0);
        step(0, 0, '0, 0, '0);
        @(posedge clk);
        #3;
        rst_n = 1'b0; clr = 0; a_valid = 0; b_valid = 0;
        #1;
        check_zero_outputs("async_reset");
        model_clear();
        last_a = '0; last_b = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, '0, 1, 8'h99);
        step(0, 1, 8'h11, 1, 8'h22);
        step(1, 0, '0, 0, '0);
        step(0, 0, '0, 0, '0);

        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stereo_stream_aligner.md
Name: stereo_stream_aligner

Overview:
- Receiving end of the pipeline delay compensation path.
- Stream A (early, e.g. left pixels) is written into a small FIFO. Stream B (late, e.g. right pixels or a matcher result after delay_line stages) drives reads from it.
- Emits time-aligned A/B pairs so downstream cost logic sees matching pixels without a fixed-length delay chain.
- Detects misalignment (overflow/underflow) and halts output until it is explicitly cleared.

Parameters:
- N, 8, data width of each stream in bits.
- DEPTH, 16, FIFO entries for stream A. Power of 2, minimum 2.
- LW, $clog2(DEPTH)+1, width of the level count (derived; do not override).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear: flushes the FIFO, clears flags, returns to RUN.
- a_valid  in  1  early-stream sample valid.
- a_data  in  N  early-stream sample.
- b_valid  in  1  late-stream sample valid.
- b_data  in  N  late-stream sample.
- o_valid  out  1  aligned pair valid.
- o_a_data  out  N  aligned A sample.
- o_b_data  out  N  aligned B sample.
- level  out  LW  current FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: an A sample was dropped.
- underflow  out  1  sticky flag: a B sample arrived with no A available.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - o_valid=0, o_a_data=0, o_b_data=0, level=0, overflow=0, underflow=0.
  - Pointers cleared; state=RUN.
- Storage: FIFO with separate read and write pointers, each one bit wider than the address (full/empty by MSB compare). Wrap-around is natural at DEPTH.
- States:
  - RUN: normal operation.
  - ERR: entered on overflow or underflow. In ERR, pushes and pops are ignored, o_valid is held 0 and level is frozen. The only exit is clr=1 (to RUN) or reset.
- RUN, push: a_valid=1 and (not full, or a pop happens in the same cycle) -> write a_data and increment the write pointer.
- RUN, pop: b_valid=1 and FIFO not empty -> read the head. On the next cycle: o_valid=1, o_a_data=head, o_b_data=b_data. Latency from B to output is 1 cycle.
- Bypass: b_valid=1 with the FIFO empty and a_valid=1 in the same cycle -> pair a_data with b_data directly. o_valid=1 next cycle; FIFO is unchanged.
- Underflow: b_valid=1, FIFO empty, a_valid=0 -> underflow<=1, state<=ERR, o_valid=0.
- Overflow: a_valid=1, FIFO full, no pop that cycle -> sample dropped, overflow<=1, state<=ERR.
- Simultaneous push and pop when full: legal, level unchanged, no overflow.
- Simultaneous push and pop when empty: handled as bypass.
- level: updates the cycle after each push/pop; +1 on push only, -1 on pop only, unchanged on both or neither.
- clr:
  - Takes priority over all data inputs in the same cycle.
  - Next cycle: pointers=0, level=0, flags=0, o_valid=0, state=RUN.
  - Inputs presented during the clr cycle are discarded.
- o_a_data/o_b_data hold their last values when o_valid=0.
- Reset mid-stream discards FIFO contents with no partial output.

Optional Feature:
- Macro: ALIGN_WATERMARK_EN.
- Defined:
  - Adds output port max_level (LW bits).
  - max_level holds the highest level reached since reset or clr, updated the cycle after level rises.
  - Reset value 0; clr sets it to 0.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Skew 3: A valid continuously from cycle 0, B valid from cycle 3, A=0x10.. incrementing -> first o_valid at cycle 4 with o_a_data=0x10, o_b_data=first B; level steady at 3; no flags.
- Zero skew: a_valid and b_valid high together, A=0x55, B=0xAA -> bypass; o_valid next cycle, 0x55/0xAA; level stays 0.
- Underflow: empty FIFO, b_valid=1, a_valid=0 -> underflow=1, state ERR, o_valid=0. Later A/B traffic gives no output and level stays 0 until clr; one cycle after clr, flags=0.
- Overflow: DEPTH=16, push 16 A samples with no B -> level=16. 17th push -> overflow=1, sample dropped. Repeat with b_valid on the 17th push -> no overflow, level=16.
- Reset mid-operation: level=5, assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately. After release, the first B with no A gives underflow.
- ALIGN_WATERMARK_EN: fill to 7, drain to 2 -> max_level=7, level=2; clr -> max_level=0.
